// File: rtl/rx_pkg.sv
// Shared definitions for the 10G MAC receive path.
// FSM encoding, Ethernet framing constants and default length limits.
package rx_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } rx_state_t;

    // DA + SA + Length/Type + FCS overhead around the payload.
    localparam int ETH_HDR_FCS_BYTES = 18;
    // Byte offset of the Length/Type MSB within the frame.
    localparam int LEN_TYPE_OFFSET   = 12;

    // Defaults shared with the RX statistics block.
    localparam int DEF_MIN_FRAME     = 64;
    localparam int DEF_MAX_FRAME     = 1518;
    localparam int DEF_MAX_LEN_FIELD = 1500;

    // Running or completed per-frame summary.
    typedef struct packed {
        logic [15:0] length;
        logic [15:0] len_type;
        logic        mask_error;
    } frame_acc_t;

    // Byte counter add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [3:0]  b
    );
        logic [16:0] sum;
        sum = {1'b0, a} + {13'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/lane_popcount.sv
// Per-word lane statistics for the 8-lane receive data path.
// Counts valid lanes and flags masks that are not a solid run from lane 0.
module lane_popcount (
    input  logic [7:0] mask,
    output logic [3:0] count,
    output logic       contiguous
);

    // Number of valid byte lanes in this word.
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b0, mask[i]};
        end
    end

    // A mask of the form 2^k-1 has no bit overlapping with mask+1.
    always_comb begin
        contiguous = ((mask + 8'd1) & mask) == 8'd0;
    end

endmodule

// File: rtl/rx_frame_length_checker.sv
// Receive frame length checker for the 10G MAC.
// Counts frame bytes, captures Length/Type and emits a one-cycle report.
module rx_frame_length_checker
    import rx_pkg::*;
#(
    parameter int MIN_FRAME     = DEF_MIN_FRAME,
    parameter int MAX_FRAME     = DEF_MAX_FRAME,
    parameter int MAX_LEN_FIELD = DEF_MAX_LEN_FIELD
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] RX_DATA,
    input  logic [7:0]  RX_VALID,
    input  logic        RX_SOF,
    input  logic        RX_EOF,
    output logic [15:0] FRAME_LENGTH,
    output logic [15:0] LEN_TYPE,
    output logic        REPORT_VALID,
    output logic        TOO_SHORT,
    output logic        TOO_LONG,
    output logic        LEN_MISMATCH,
    output logic        MASK_ERROR,
    output logic        ABORTED
);

    localparam logic [15:0] MIN_L  = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_L  = 16'(MAX_FRAME);
    localparam logic [15:0] MAX_LF = 16'(MAX_LEN_FIELD);
    localparam logic [15:0] HDR_L  = 16'(ETH_HDR_FCS_BYTES);
    localparam logic [16:0] LT_HI  = 17'(LEN_TYPE_OFFSET);
    localparam logic [16:0] LT_LO  = 17'(LEN_TYPE_OFFSET + 1);

    rx_state_t  state;
    rx_state_t  state_next;

    frame_acc_t frame_q;
    frame_acc_t word_new;
    frame_acc_t word_acc;
    frame_acc_t rep_src;

    logic        pending;
    logic        pend_next;

    logic [3:0]  word_bytes;
    logic        word_contig;
    logic        word_act;
    logic        word_merr;
    logic [15:0] acc_lt;
    logic [16:0] lane_off;

    logic        ev_start;
    logic        ev_single;
    logic        ev_accum;
    logic        ev_finish;
    logic        ev_abort;

    logic        rep_fire;
    logic        rep_abort;
    logic        load_new;
    logic        load_acc;

    logic        rep_short;
    logic        rep_long;
    logic        rep_mismatch;

    lane_popcount u_pop (
        .mask       (RX_VALID),
        .count      (word_bytes),
        .contiguous (word_contig)
    );

    assign word_act  = |RX_VALID;
    assign word_merr = word_act &&
                       (!word_contig ||
                        (!RX_EOF && RX_VALID != 8'hFF));

    // Word classification; an all-invalid word never moves the FSM.
    always_comb begin
        ev_start  = 1'b0;
        ev_single = 1'b0;
        ev_accum  = 1'b0;
        ev_finish = 1'b0;
        ev_abort  = 1'b0;
        if (word_act) begin
            if (state == IDLE) begin
                ev_start  = RX_SOF && !RX_EOF;
                ev_single = RX_SOF && RX_EOF;
            end else begin
                ev_abort  = RX_SOF;
                ev_finish = !RX_SOF && RX_EOF;
                ev_accum  = !RX_SOF && !RX_EOF;
            end
        end
    end

    // Length/Type capture: lane offset is bytes-so-far plus lane index.
    always_comb begin
        acc_lt   = frame_q.len_type;
        lane_off = '0;
        for (int i = 0; i < 8; i++) begin
            if (RX_VALID[i]) begin
                lane_off = {1'b0, frame_q.length} + 17'(i);
                if (lane_off == LT_HI) begin
                    acc_lt[15:8] = RX_DATA[8*i +: 8];
                end else if (lane_off == LT_LO) begin
                    acc_lt[7:0] = RX_DATA[8*i +: 8];
                end
            end
        end
    end

    // Frame summaries if this word starts a frame or extends the current one.
    // A first word only spans offsets 0..7, so it never reaches Length/Type.
    always_comb begin
        word_new.length     = {12'b0, word_bytes};
        word_new.len_type   = '0;
        word_new.mask_error = word_merr;
        word_acc.length     = sat_add(frame_q.length, word_bytes);
        word_acc.len_type   = acc_lt;
        word_acc.mask_error = frame_q.mask_error | word_merr;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (1'b1)
            ev_start:  state_next = IN_FRAME;
            ev_finish: state_next = IDLE;
            ev_abort:  state_next = RX_EOF ? IDLE : IN_FRAME;
            default:   state_next = state;
        endcase
    end

    // FSM outputs: report source selection and frame register loads.
    // A held frame (pending) always reports first; a single-word frame
    // arriving in that same cycle is parked behind it.
    always_comb begin
        rep_fire  = 1'b0;
        rep_src   = '0;
        rep_abort = 1'b0;
        load_new  = 1'b0;
        load_acc  = 1'b0;
        pend_next = 1'b0;
        if (pending) begin
            rep_fire = 1'b1;
            rep_src  = frame_q;
        end
        unique case (1'b1)
            ev_start: begin
                load_new = 1'b1;
            end
            ev_single: begin
                if (pending) begin
                    load_new  = 1'b1;
                    pend_next = 1'b1;
                end else begin
                    rep_fire = 1'b1;
                    rep_src  = word_new;
                end
            end
            ev_accum: begin
                load_acc = 1'b1;
            end
            ev_finish: begin
                rep_fire = 1'b1;
                rep_src  = word_acc;
            end
            ev_abort: begin
                rep_fire  = 1'b1;
                rep_src   = frame_q;
                rep_abort = 1'b1;
                load_new  = 1'b1;
                pend_next = RX_EOF;
            end
            default: ;
        endcase
    end

    // Length checks on whichever frame is being reported.
    always_comb begin
        rep_short    = rep_src.length < MIN_L;
        rep_long     = rep_src.length > MAX_L;
        rep_mismatch = (rep_src.len_type <= MAX_LF) &&
                       ((rep_src.length < HDR_L) ||
                        (rep_src.len_type > rep_src.length - HDR_L));
    end

    // Frame accumulator and held-report flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_q <= '0;
            pending <= 1'b0;
        end else begin
            pending <= pend_next;
            if (load_new) begin
                frame_q <= word_new;
            end else if (load_acc) begin
                frame_q <= word_acc;
            end
        end
    end

    // Registered report; fields hold until the next report.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            REPORT_VALID <= 1'b0;
            FRAME_LENGTH <= '0;
            LEN_TYPE     <= '0;
            TOO_SHORT    <= 1'b0;
            TOO_LONG     <= 1'b0;
            LEN_MISMATCH <= 1'b0;
            MASK_ERROR   <= 1'b0;
            ABORTED      <= 1'b0;
        end else begin
            REPORT_VALID <= rep_fire;
            if (rep_fire) begin
                FRAME_LENGTH <= rep_src.length;
                LEN_TYPE     <= rep_src.len_type;
                TOO_SHORT    <= rep_short;
                TOO_LONG     <= rep_long;
                LEN_MISMATCH <= rep_mismatch;
                MASK_ERROR   <= rep_src.mask_error;
                ABORTED      <= rep_abort;
            end
        end
    end

endmodule
